next_piece_gen: RTL and testbench

Seven-bag random piece generator feeding the side-panel preview and the falling-piece logic. It holds one "next" tetromino, decodes it into the 4x4 colour grid consumed by the menu renderer (`menu_shape`), and hands the piece to the game FSM on request. After each hand-off it draws a replacement from a 16-bit LFSR.

---
 rtl/tetris_pkg.sv | 19 +
 rtl/lfsr16.sv | 11 +
 rtl/next_piece_gen.sv | 62 ++++++
 tb/tb_next_piece_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: piece codes, rotation-0 shape masks, LFSR taps and bag helpers
package tetris_pkg;
  typedef logic [2:0] piece_t;
  localparam piece_t P_NONE = 3'd0;
  localparam piece_t P_I = 3'd1;
  localparam piece_t P_O = 3'd2;
  localparam piece_t P_T = 3'd3;
  localparam piece_t P_S = 3'd4;
  localparam piece_t P_Z = 3'd5;
  localparam piece_t P_J = 3'd6;
  localparam piece_t P_L = 3'd7;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] SHAPE_ROM [7] = '{16'h00F0, 16'h0066, 16'h0072, 16'h0036, 16'h0063, 16'h0071, 16'h0074};
  typedef enum logic [1:0] {DRAW, IDLE, HALT} state_t;
  function automatic piece_t lowest_piece(input logic [6:0] bag);
    lowest_piece = P_NONE;
    for (int k = 6; k >= 0; k--) if (bag[k]) lowest_piece = piece_t'(k + 1);
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR loaded with seed on reset
module lfsr16 import tetris_pkg::*; (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= seed;
    else q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
endmodule

// File: rtl/next_piece_gen.sv
// next_piece_gen: seven-bag preview piece generator with spawn handshake and shape decode
module next_piece_gen import tetris_pkg::*; #(
  parameter int          BLK_PER_SHAPE = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             spawn_req,
  input  logic                             lose,
  output logic                             ready,
  output logic                             piece_valid,
  output logic [2:0]                       piece_id,
  output logic [2:0]                       next_id,
  output logic [3*BLK_PER_SHAPE**2-1:0]    menu_shape
);
  localparam int N = BLK_PER_SHAPE ** 2;
  state_t state;
  logic [6:0] bag, left;
  logic [2:0] tries;
  logic [15:0] lfsr;
  piece_t cand, pick;
  logic hit, take, unused_lfsr;
  logic [N-1:0] row;
  lfsr16 u_lfsr (.clk(clk), .reset_n(reset_n), .seed(LFSR_SEED), .q(lfsr));
  assign unused_lfsr = ^lfsr[15:3];
  assign cand = lfsr[2:0];
  assign hit = cand != 3'd0 && bag[cand - 3'd1];
  // after seven rejections fall back to the lowest piece left so a draw never exceeds 8 cycles
  assign pick = hit ? cand : lowest_piece(bag);
  assign take = hit || tries == 3'd7;
  assign left = bag & ~(7'd1 << (pick - 3'd1));
  assign ready = state == IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= DRAW;
      bag         <= 7'h7F;
      tries       <= 3'd0;
      next_id     <= P_NONE;
      piece_id    <= P_NONE;
      piece_valid <= 1'b0;
    end else begin
      piece_valid <= 1'b0;
      if (lose) state <= HALT;
      else if (state == DRAW) begin
        if (take) begin
          next_id <= pick;
          bag     <= left == '0 ? 7'h7F : left;
          tries   <= 3'd0;
          state   <= IDLE;
        end else tries <= tries + 3'd1;
      end else if (state == IDLE && spawn_req) begin
        piece_id    <= next_id;
        piece_valid <= 1'b1;
        state       <= DRAW;
      end
    end
  assign row = next_id == P_NONE ? '0 : N'(SHAPE_ROM[next_id - 3'd1]);
  genvar g;
  for (g = 0; g < N; g++) begin : g_cell
    assign menu_shape[3*g +: 3] = row[g] ? next_id : 3'd0;
  end
endmodule

// File: tb/tb_next_piece_gen.sv
// tb_next_piece_gen: directed bench with a behavioural seven-bag model checked every cycle
module tb_next_piece_gen;
  logic clk = 1'b0, reset_n = 1'b0, spawn_req = 1'b0, lose = 1'b0;
  logic ready, piece_valid;
  logic [2:0] piece_id, next_id;
  logic [47:0] menu_shape;
  int tests = 0, fails = 0;
  localparam int M_DRAW = 0, M_IDLE = 1, M_HALT = 2;
  int cells [8][4] = '{'{0,0,0,0}, '{4,5,6,7}, '{1,2,5,6}, '{1,4,5,6}, '{1,2,4,5}, '{0,1,5,6}, '{0,4,5,6}, '{2,4,5,6}};
  logic [15:0] m_lfsr;
  int m_mode, m_tries, m_next, m_pid;
  bit m_pv, prev_pv;
  bit avail [8];
  logic [2:0] seq[$], ref_seq[$];

  next_piece_gen dut (.clk(clk), .reset_n(reset_n), .spawn_req(spawn_req), .lose(lose), .ready(ready),
                      .piece_valid(piece_valid), .piece_id(piece_id), .next_id(next_id), .menu_shape(menu_shape));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] shape_of(input int p);
    logic [47:0] s = '0;
    if (p != 0) for (int j = 0; j < 4; j++) s[3*cells[p][j] +: 3] = 3'(p);
    return s;
  endfunction

  initial begin : model
    int c, pick;
    logic [15:0] cur;
    bit any;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_lfsr = 16'hACE1; m_mode = M_DRAW; m_tries = 0; m_next = 0; m_pid = 0; m_pv = 0;
        for (int p = 1; p <= 7; p++) avail[p] = 1;
      end else begin
        cur = m_lfsr;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        m_pv = 0;
        if (lose) m_mode = M_HALT;
        else if (m_mode == M_DRAW) begin
          c = int'(cur[2:0]);
          pick = 0;
          if (c != 0 && avail[c]) pick = c;
          else if (m_tries == 7) begin
            for (int p = 7; p >= 1; p--) if (avail[p]) pick = p;
          end else m_tries++;
          if (pick != 0) begin
            m_next = pick; avail[pick] = 0; any = 0;
            for (int p = 1; p <= 7; p++) any |= avail[p];
            if (!any) for (int p = 1; p <= 7; p++) avail[p] = 1;
            m_tries = 0; m_mode = M_IDLE;
          end
        end else if (m_mode == M_IDLE && spawn_req) begin
          m_pid = m_next; m_pv = 1; m_mode = M_DRAW;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ready", ready, m_mode == M_IDLE);
    chk("piece_valid", piece_valid, m_pv);
    chk("piece_id", piece_id, m_pid);
    chk("next_id", next_id, m_next);
    chk("menu_shape", menu_shape, shape_of(m_next));
    if (piece_valid) chk("pv_width", prev_pv, 0);
    prev_pv = piece_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals();
    chk("rst_next_id", next_id, 0);
    chk("rst_ready", ready, 0);
    chk("rst_piece_valid", piece_valid, 0);
    chk("rst_piece_id", piece_id, 0);
    chk("rst_menu_shape", menu_shape, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin cyc(); n++; end
    chk("ready_timeout", ready, 1);
  endtask

  task automatic run_bag();
    logic [7:0] mask;
    check_reset_vals();
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("first_next_id", next_id, 1);
    chk("first_ready", ready, 1);
    chk("first_shape", menu_shape, 48'h0000_0024_9000);
    seq.delete();
    spawn_req = 1'b1;
    for (int i = 0; i < 300 && seq.size() < 14; i++) begin
      cyc();
      if (piece_valid) seq.push_back(piece_id);
      if (seq.size() == 14) spawn_req = 1'b0;
    end
    spawn_req = 1'b0;
    chk("accept_count", seq.size(), 14);
    if (seq.size() == 14) begin
      chk("seq0", seq[0], 1);
      chk("seq1", seq[1], 4);
      for (int b = 0; b < 2; b++) begin
        mask = '0;
        for (int j = 0; j < 7; j++) mask |= 8'd1 << seq[7*b + j];
        chk("bag_perm", mask, 8'hFE);
      end
    end
  endtask

  initial begin
    int n, lat;
    logic [2:0] nid;
    logic [47:0] sh;
    repeat (3) cyc();
    run_bag();
    ref_seq = seq;
    wait_ready();
    spawn_req = 1'b1;
    cyc();
    chk("hs_pv", piece_valid, 1);
    chk("hs_busy", ready, 0);
    cyc();
    spawn_req = 1'b0;
    n = 0;
    repeat (12) begin if (piece_valid) n++; cyc(); end
    chk("hs_no_pulse", n, 0);
    for (int i = 0; i < 2000; i++) begin
      wait_ready();
      chk("next_nonzero", next_id != 3'd0, 1);
      repeat ($urandom_range(0, 3)) cyc();
      spawn_req = 1'b1;
      cyc();
      spawn_req = 1'b0;
      lat = 1;
      while (!ready && lat < 12) begin cyc(); lat++; end
      chk("latency", lat <= 9, 1);
    end
    wait_ready();
    spawn_req = 1'b1;
    cyc();
    spawn_req = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    cyc();
    run_bag();
    chk("reseed_len", seq.size(), ref_seq.size());
    if (seq.size() == ref_seq.size()) for (int i = 0; i < seq.size(); i++) chk("reseed_seq", seq[i], ref_seq[i]);
    wait_ready();
    nid = next_id;
    sh = menu_shape;
    spawn_req = 1'b1;
    lose = 1'b1;
    cyc();
    lose = 1'b0;
    repeat (100) begin
      chk("halt_pv", piece_valid, 0);
      chk("halt_ready", ready, 0);
      chk("halt_next", next_id, nid);
      chk("halt_shape", menu_shape, sh);
      cyc();
    end
    spawn_req = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
